alu_share_sched: RTL and testbench

//  Shares one combinational NZVC ALU between NREQ requesters using round-robin arbitration.

---
 rtl/alu_ctrl_pkg.sv | 12 +
 rtl/alu_share_sched_if.sv | 21 ++
 rtl/rr_arbiter.sv | 22 ++
 rtl/alu_share_sched.sv | 73 +++++++
 tb/tb_alu_share_sched.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared FSM states, flag struct and ALU op codes
package alu_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } nzvc_t;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
endpackage

// File: rtl/alu_share_sched_if.sv
// alu_share_sched_if: requester-side request/response bundle of the ALU scheduler
interface alu_share_sched_if #(parameter int XLEN = 32, parameter int NREQ = 2);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;
  logic [NREQ*4-1:0]    req_op;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [XLEN-1:0]      rsp_s;
  logic [3:0]           rsp_nzvc;
  logic                 rsp_err;
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_s, rsp_nzvc, rsp_err
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_s, rsp_nzvc, rsp_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);
  // Scan from the farthest offset down so the nearest requester overwrites last
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        grant = NREQ'(1) << ((int'(ptr) + i) % NREQ);
        idx   = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end
endmodule

// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin sharing of one NZVC ALU with registered operands and response
module alu_share_sched
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_sched_if.slave    bus,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output logic [3:0]          alu_op,
  input  logic [XLEN-1:0]     alu_s,
  input  logic                alu_n,
  input  logic                alu_z,
  input  logic                alu_v,
  input  logic                alu_c,
  input  logic                alu_hata,
  output logic [3:0]          flags_q,
  output logic                busy
);
  localparam int PW = $clog2(NREQ);
  state_t state, next;
  logic [PW-1:0] rr_ptr, gsel, gidx;
  logic [NREQ-1:0] grant;
  logic rsp_ok;
  nzvc_t nzvc;
  assign nzvc = '{n: alu_n, z: alu_z, v: alu_v, c: alu_c};
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (bus.req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (gidx)
  );
  always_comb begin
    rsp_ok        = state == RESP && bus.rsp_ready[gsel];
    next          = state == IDLE ? (|grant ? EXEC : IDLE) : state == EXEC ? RESP : (rsp_ok ? IDLE : RESP);
    bus.req_ready = state == IDLE ? grant : '0;
    bus.rsp_valid = state == RESP ? NREQ'(1) << gsel : '0;
    busy          = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gsel         <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      bus.rsp_s    <= '0;
      bus.rsp_nzvc <= '0;
      bus.rsp_err  <= 1'b0;
      flags_q      <= '0;
    end else begin
      state <= next;
      if (state == IDLE && |grant) begin
        alu_a  <= bus.req_a[gidx*XLEN +: XLEN];
        alu_b  <= bus.req_b[gidx*XLEN +: XLEN];
        alu_op <= bus.req_op[gidx*4 +: 4];
        gsel   <= gidx;
      end
      // Error results are reported but never touch the architectural flags
      if (state == EXEC) begin
        bus.rsp_s    <= alu_s;
        bus.rsp_nzvc <= nzvc;
        bus.rsp_err  <= alu_hata;
        if (!alu_hata) flags_q <= nzvc;
      end
      if (rsp_ok) rr_ptr <= gsel == PW'(NREQ - 1) ? '0 : gsel + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: scoreboard bench for the shared-ALU scheduler with a behavioural ALU stub
module tb_alu_share_sched;
  import alu_ctrl_pkg::*;
  localparam int XLEN = 32;
  localparam int NREQ = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  alu_share_sched_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();
  logic [31:0] alu_a, alu_b, alu_s;
  logic [3:0]  alu_op, flags_q;
  logic        alu_n, alu_z, alu_v, alu_c, alu_hata, busy;
  alu_share_sched #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .alu_hata(alu_hata), .flags_q(flags_q), .busy(busy)
  );
  logic [32:0] sum;
  always_comb begin
    sum      = 33'd0;
    alu_hata = 1'b0;
    if (alu_op == OP_ADD) sum = {1'b0, alu_a} + {1'b0, alu_b};
    else if (alu_op == OP_SUB) sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    else alu_hata = 1'b1;
    alu_s = sum[31:0];
    alu_c = sum[32];
    alu_n = sum[31];
    alu_z = ~alu_hata && sum[31:0] == 32'd0;
    alu_v = alu_op == OP_ADD ? (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]) :
            alu_op == OP_SUB ? (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]) : 1'b0;
  end
  typedef struct {
    int          k;
    logic [31:0] s;
    logic [3:0]  nzvc;
    logic        err;
    logic [3:0]  flags;
  } exp_t;
  exp_t sb[$];
  int vectors = 0;
  int errors = 0;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.req_a[k*32 +: 32] = a;
    bus.req_b[k*32 +: 32] = b;
    bus.req_op[k*4 +: 4]  = op;
    bus.req_valid[k]      = 1'b1;
  endtask
  task automatic accept(input int k, input exp_t e, input bit push);
    int n = 0;
    #1;
    while (bus.req_ready === '0 && n < 10) begin
      tick;
      n++;
    end
    vectors++;
    if (bus.req_ready !== (2'b01 << k)) begin
      errors++;
      $display("FAIL accept req_ready got %b exp %b after %0d cycles", bus.req_ready, 2'b01 << k, n);
    end
    if (push) sb.push_back(e);
  endtask
  task automatic check_rsp(input int k);
    exp_t e;
    vectors++;
    if (bus.rsp_valid !== (2'b01 << k)) begin
      errors++;
      $display("FAIL rsp_valid got %b exp %b", bus.rsp_valid, 2'b01 << k);
    end
    vectors++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard got empty exp entry");
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (bus.rsp_s !== e.s) begin
      errors++;
      $display("FAIL rsp_s got %h exp %h", bus.rsp_s, e.s);
    end
    vectors++;
    if (bus.rsp_nzvc !== e.nzvc) begin
      errors++;
      $display("FAIL rsp_nzvc got %b exp %b", bus.rsp_nzvc, e.nzvc);
    end
    vectors++;
    if (bus.rsp_err !== e.err) begin
      errors++;
      $display("FAIL rsp_err got %b exp %b", bus.rsp_err, e.err);
    end
    vectors++;
    if (flags_q !== e.flags) begin
      errors++;
      $display("FAIL flags_q got %b exp %b", flags_q, e.flags);
    end
  endtask
  task automatic handshake(input int k);
    bus.rsp_ready[k] = 1'b1;
    tick;
    bus.rsp_ready[k] = 1'b0;
    #1;
    vectors++;
    if (bus.rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_handshake rsp_valid/busy got %b/%b exp 00/0", bus.rsp_valid, busy);
    end
  endtask
  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [31:0] es, input logic [3:0] en, input logic ee, input logic [3:0] ef);
    set_req(k, a, b, op);
    accept(k, '{k: k, s: es, nzvc: en, err: ee, flags: ef}, 1'b1);
    tick;
    bus.req_valid[k] = 1'b0;
    #1;
    vectors++;
    if (bus.rsp_valid !== 2'b00 || busy !== 1'b1 || alu_a !== a || alu_b !== b || alu_op !== op) begin
      errors++;
      $display("FAIL exec rsp_valid %b busy %b alu_a %h alu_b %h alu_op %h exp 00 1 %h %h %h",
               bus.rsp_valid, busy, alu_a, alu_b, alu_op, a, b, op);
    end
    tick;
    check_rsp(k);
    handshake(k);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || flags_q !== 4'h0 || bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl busy %b flags %b rsp_valid %b req_ready %b exp 0 0000 00 00",
               busy, flags_q, bus.rsp_valid, bus.req_ready);
    end
    vectors++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'h0 || bus.rsp_s !== 32'h0 ||
        bus.rsp_nzvc !== 4'h0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data alu_a %h alu_b %h alu_op %h rsp_s %h nzvc %b err %b exp all zero",
               alu_a, alu_b, alu_op, bus.rsp_s, bus.rsp_nzvc, bus.rsp_err);
    end
  endtask
  task automatic test_single;
    do_op(0, 32'h7FFFFFFF, 32'h1, OP_ADD, 32'h80000000, 4'b1010, 1'b0, 4'b1010);
  endtask
  task automatic test_carry_zero;
    do_op(1, 32'hFFFFFFFF, 32'h1, OP_ADD, 32'h0, 4'b0101, 1'b0, 4'b0101);
  endtask
  task automatic test_invalid;
    do_op(0, 32'h12345678, 32'h9, 4'hF, 32'h0, 4'b0000, 1'b1, 4'b0101);
  endtask
  task automatic test_fairness;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_req(0, 32'h5, 32'h3, OP_ADD);
    set_req(1, 32'h80000000, 32'h80000000, OP_ADD);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) accept(0, '{k: 0, s: 32'h8, nzvc: 4'b0000, err: 1'b0, flags: 4'b0000}, 1'b1);
      else accept(1, '{k: 1, s: 32'h0, nzvc: 4'b0111, err: 1'b0, flags: 4'b0111}, 1'b1);
      tick;
      vectors++;
      if (bus.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL fair_hold req_ready got %b exp 00", bus.req_ready);
      end
      tick;
      check_rsp(i % 2);
      bus.rsp_ready[i % 2] = 1'b1;
      tick;
      bus.rsp_ready[i % 2] = 1'b0;
    end
    bus.req_valid = '0;
    tick;
  endtask
  task automatic test_reset_exec;
    set_req(0, 32'h1, 32'h1, OP_ADD);
    accept(0, '{k: 0, s: 32'h2, nzvc: 4'b0000, err: 1'b0, flags: 4'b0000}, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.rsp_valid !== 2'b00 || flags_q !== 4'h0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_exec rsp_valid %b flags %b busy %b exp 00 0000 0", bus.rsp_valid, flags_q, busy);
      end
      tick;
    end
    do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_ADD, 32'hFFFFFFFE, 4'b1001, 1'b0, 4'b1001);
  endtask
  task automatic test_backpressure;
    set_req(1, 32'h2, 32'h2, OP_ADD);
    accept(1, '{k: 1, s: 32'h4, nzvc: 4'b0000, err: 1'b0, flags: 4'b0000}, 1'b1);
    tick;
    bus.req_valid[1] = 1'b0;
    tick;
    set_req(0, 32'h6, 32'h6, OP_ADD);
    bus.rsp_ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_s !== 32'h4 || bus.req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure rsp_valid %b rsp_s %h req_ready %b busy %b exp 10 00000004 00 1",
                 bus.rsp_valid, bus.rsp_s, bus.req_ready, busy);
      end
      tick;
    end
    bus.rsp_ready[0] = 1'b0;
    bus.req_valid[0] = 1'b0;
    #1;
    check_rsp(1);
    handshake(1);
  endtask
  initial begin
    test_reset;
    test_single;
    test_carry_zero;
    test_invalid;
    test_fairness;
    test_reset_exec;
    test_backpressure;
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
